// File: rtl/mdu_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
// Cancel exists only when MDU_CANCEL_EN is defined.
interface mdu_if;
  logic        Start;
  logic [2:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        ReadSel;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] Out;
`ifdef MDU_CANCEL_EN
  logic        Cancel;

  modport master (
    output Start, MDUOp, A, B, ReadSel, Cancel,
    input  Busy, HI, LO, Out
  );
  modport slave (
    input  Start, MDUOp, A, B, ReadSel, Cancel,
    output Busy, HI, LO, Out
  );
`else
  modport master (
    output Start, MDUOp, A, B, ReadSel,
    input  Busy, HI, LO, Out
  );
  modport slave (
    input  Start, MDUOp, A, B, ReadSel,
    output Busy, HI, LO, Out
  );
`endif
endinterface

// File: rtl/mdu_ctrl.sv
// HI/LO owner and latency sequencer for mult/multu/div/divu/mthi/mtlo.
// Optional flush input enabled by defining MDU_CANCEL_EN.
module mdu_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        busy_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [63:0] pend;

  logic        cancel;
  logic        op_mul;
  logic        op_mulu;
  logic        op_div;
  logic        op_divu;
  logic        op_mthi;
  logic        op_mtlo;
  logic        op_long;
  logic        sgn;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] q;
  logic [31:0] r;
  logic [63:0] res;

`ifdef MDU_CANCEL_EN
  assign cancel = bus.Cancel;
`else
  assign cancel = 1'b0;
`endif

  assign op_mul  = bus.MDUOp == 3'd1;
  assign op_mulu = bus.MDUOp == 3'd2;
  assign op_div  = bus.MDUOp == 3'd3;
  assign op_divu = bus.MDUOp == 3'd4;
  assign op_mthi = bus.MDUOp == 3'd5;
  assign op_mtlo = bus.MDUOp == 3'd6;
  assign op_long = op_mul | op_mulu | op_div | op_divu;

  // Divide on magnitudes, then restore signs; this also yields
  // 0x80000000 for the -2^31 / -1 overflow case.
  always_comb begin
    sgn = op_div;
    dvd = (sgn && bus.A[31]) ? 32'd0 - bus.A : bus.A;
    dvs = (sgn && bus.B[31]) ? 32'd0 - bus.B : bus.B;
    q   = '0;
    r   = '0;
    if (dvs != '0) begin
      q = dvd / dvs;
      r = dvd % dvs;
    end
    if (sgn && (bus.A[31] ^ bus.B[31])) q = 32'd0 - q;
    if (sgn && bus.A[31])               r = 32'd0 - r;
  end

  always_comb begin
    res = {hi_q, lo_q};
    unique case (1'b1)
      op_mul:
        res = {{32{bus.A[31]}}, bus.A} *
              {{32{bus.B[31]}}, bus.B};
      op_mulu:
        res = {32'd0, bus.A} * {32'd0, bus.B};
      op_div, op_divu:
        if (bus.B != '0) res = {r, q};
      default: res = {hi_q, lo_q};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      pend   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.Start && !cancel) begin
            if (op_long) begin
              pend   <= res;
              cnt    <= (op_div | op_divu) ? 4'(DIV_CYC)
                                           : 4'(MULT_CYC);
              busy_q <= 1'b1;
              state  <= RUN;
            end else if (op_mthi) begin
              hi_q <= bus.A;
            end else if (op_mtlo) begin
              lo_q <= bus.A;
            end
          end
        end
        RUN: begin
          if (cancel) begin
            cnt    <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (cnt == 4'd1) begin
            cnt    <= '0;
            busy_q <= 1'b0;
            hi_q   <= pend[63:32];
            lo_q   <= pend[31:0];
            state  <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
      endcase
    end
  end

  assign bus.Busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
  assign bus.Out  = bus.ReadSel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomised and directed bench for mdu_ctrl against a behavioural
// HI/LO model; cancel scenarios run when MDU_CANCEL_EN is defined.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_if bus ();

  mdu_ctrl #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_res(
    input logic [2:0]  op,
    input logic [31:0] a, b, hi, lo
  );
    longint sa, sb, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: return 64'(sa * sb);
      3'd2: begin
        u = {32'd0, a} * {32'd0, b};
        return u;
      end
      3'd3: begin
        if (b == 0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 0) return {hi, lo};
        return {a % b, a / b};
      end
      3'd5: return {a, lo};
      3'd6: return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction

  function automatic int exp_busy(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return MC;
    if (op == 3'd3 || op == 3'd4) return DC;
    return 0;
  endfunction

  // Called at a negedge; returns at the negedge after the issuing edge.
  task automatic drive(input logic [2:0] op, input logic [31:0] a, b);
    bus.Start = 1'b1;
    bus.MDUOp = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    bus.MDUOp = 3'd0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (bus.Busy === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset       = 1'b0;
    bus.Start   = 1'b0;
    bus.MDUOp   = 3'd0;
    bus.A       = '0;
    bus.B       = '0;
    bus.ReadSel = 1'b0;
`ifdef MDU_CANCEL_EN
    bus.Cancel  = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.HI !== 32'd0) begin
      n_err++; $display("FAIL reset_hi got %h want 0", bus.HI);
    end
    n_cmp++;
    if (bus.LO !== 32'd0) begin
      n_err++; $display("FAIL reset_lo got %h want 0", bus.LO);
    end
    n_cmp++;
    if (bus.Busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy got %b want 0", bus.Busy);
    end
    n_cmp++;
    if (bus.Out !== 32'd0) begin
      n_err++; $display("FAIL reset_out got %h want 0", bus.Out);
    end
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic test_mult;
    int n;
    drive(3'd1, 32'hFFFF_FFFE, 32'd3);
    n = 0;
    while (bus.Busy === 1'b1 && n < 64) begin
      n_cmp++;
      if (bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
        n_err++;
        $display("FAIL mult_hold got %h_%h want 0_0", bus.HI, bus.LO);
      end
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if (n != MC) begin
      n_err++; $display("FAIL mult_busy got %0d want %0d", n, MC);
    end
    n_cmp++;
    if ({bus.HI, bus.LO} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
      n_err++;
      $display("FAIL mult_res got %h_%h want ffffffff_fffffffa",
               bus.HI, bus.LO);
    end
    {m_hi, m_lo} = 64'hFFFF_FFFF_FFFF_FFFA;
  endtask

  task automatic test_multu_divu;
    int n;
    drive(3'd2, 32'hFFFF_FFFF, 32'd2);
    busy_len(n);
    n_cmp++;
    if (n != MC || {bus.HI, bus.LO} !== 64'h1_FFFF_FFFE) begin
      n_err++;
      $display("FAIL multu busy %0d res %h_%h want %0d 00000001_fffffffe",
               n, bus.HI, bus.LO, MC);
    end
    drive(3'd4, 32'd7, 32'd2);
    busy_len(n);
    n_cmp++;
    if (n != DC || {bus.HI, bus.LO} !== {32'd1, 32'd3}) begin
      n_err++;
      $display("FAIL divu busy %0d res %h_%h want %0d 00000001_00000003",
               n, bus.HI, bus.LO, DC);
    end
    {m_hi, m_lo} = {32'd1, 32'd3};
  endtask

  task automatic test_div;
    int n;
    drive(3'd3, 32'hFFFF_FFF9, 32'd2);
    busy_len(n);
    n_cmp++;
    if (n != DC || {bus.HI, bus.LO} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      n_err++;
      $display("FAIL div_neg busy %0d res %h_%h want %0d ffffffff_fffffffd",
               n, bus.HI, bus.LO, DC);
    end
    drive(3'd3, 32'd5, 32'd0);
    busy_len(n);
    n_cmp++;
    if (n != DC || {bus.HI, bus.LO} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      n_err++;
      $display("FAIL div_zero busy %0d res %h_%h want %0d ffffffff_fffffffd",
               n, bus.HI, bus.LO, DC);
    end
    drive(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    busy_len(n);
    n_cmp++;
    if ({bus.HI, bus.LO} !== 64'h0000_0000_8000_0000) begin
      n_err++;
      $display("FAIL div_ovf res %h_%h want 00000000_80000000",
               bus.HI, bus.LO);
    end
    {m_hi, m_lo} = 64'h0000_0000_8000_0000;
  endtask

  task automatic test_mt_ignore;
    int n;
    drive(3'd5, 32'hDEAD_0001, 32'd0);
    drive(3'd6, 32'h0000_1234, 32'd0);
    bus.ReadSel = 1'b0;
    #1;
    n_cmp++;
    if (bus.LO !== 32'h1234 || bus.Busy !== 1'b0 ||
        bus.Out !== 32'h1234) begin
      n_err++;
      $display("FAIL mtlo lo %h busy %b out %h want 00001234 0 00001234",
               bus.LO, bus.Busy, bus.Out);
    end
    bus.ReadSel = 1'b1;
    #1;
    n_cmp++;
    if (bus.Out !== 32'hDEAD_0001) begin
      n_err++; $display("FAIL mthi_out got %h want dead0001", bus.Out);
    end
    @(negedge clk);
    drive(3'd1, 32'd2, 32'd3);
    drive(3'd5, 32'h55, 32'd0);
    busy_len(n);
    n_cmp++;
    if (n != MC - 1 || {bus.HI, bus.LO} !== {32'd0, 32'd6}) begin
      n_err++;
      $display("FAIL mt_ignored busy %0d res %h_%h want %0d 0_6",
               n, bus.HI, bus.LO, MC - 1);
    end
    {m_hi, m_lo} = {32'd0, 32'd6};
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] v [2];
    logic [63:0] e;
    int n;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 7))
          0: v[k] = 32'd0;
          1: v[k] = 32'h8000_0000;
          2: v[k] = 32'hFFFF_FFFF;
          3: v[k] = 32'($urandom_range(0, 20));
          default: v[k] = $urandom;
        endcase
      end
      bus.ReadSel = 1'($urandom_range(0, 1));
      e = ref_res(op, v[0], v[1], m_hi, m_lo);
      drive(op, v[0], v[1]);
      busy_len(n);
      {m_hi, m_lo} = e;
      n_cmp++;
      if (n != exp_busy(op) || bus.HI !== m_hi || bus.LO !== m_lo ||
          bus.Out !== (bus.ReadSel ? m_hi : m_lo)) begin
        n_err++;
        $display("FAIL rand%0d op%0d a=%h b=%h busy %0d res %h_%h out %h want %0d %h_%h",
                 i, op, v[0], v[1], n, bus.HI, bus.LO, bus.Out,
                 exp_busy(op), m_hi, m_lo);
      end
    end
  endtask

  task automatic test_reset_mid;
    drive(3'd6, 32'hA5A5, 32'd0);
    drive(3'd1, 32'd7, 32'd9);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.Busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid busy %b res %h_%h want 0 0_0",
               bus.Busy, bus.HI, bus.LO);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (MC + 2) @(negedge clk);
    n_cmp++;
    if (bus.Busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      n_err++;
      $display("FAIL reset_drop busy %b res %h_%h want 0 0_0",
               bus.Busy, bus.HI, bus.LO);
    end
    m_hi = '0;
    m_lo = '0;
  endtask

`ifdef MDU_CANCEL_EN
  task automatic test_cancel;
    drive(3'd5, 32'h11, 32'd0);
    drive(3'd6, 32'h22, 32'd0);
    drive(3'd3, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    bus.Cancel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.Cancel = 1'b0;
    n_cmp++;
    if (bus.Busy !== 1'b0 || {bus.HI, bus.LO} !== {32'h11, 32'h22}) begin
      n_err++;
      $display("FAIL cancel_run busy %b res %h_%h want 0 11_22",
               bus.Busy, bus.HI, bus.LO);
    end
    repeat (DC) @(negedge clk);
    n_cmp++;
    if ({bus.HI, bus.LO} !== {32'h11, 32'h22}) begin
      n_err++;
      $display("FAIL cancel_drop res %h_%h want 11_22", bus.HI, bus.LO);
    end
    bus.Cancel = 1'b1;
    drive(3'd6, 32'h99, 32'd0);
    bus.Cancel = 1'b1;
    drive(3'd1, 32'd4, 32'd4);
    bus.Cancel = 1'b0;
    n_cmp++;
    if (bus.LO !== 32'h22 || bus.Busy !== 1'b0) begin
      n_err++;
      $display("FAIL cancel_start lo %h busy %b want 22 0",
               bus.LO, bus.Busy);
    end
    m_hi = 32'h11;
    m_lo = 32'h22;
  endtask
`endif

  initial begin
    reset = 1'b0;
    @(negedge clk);
    test_reset;
    test_mult;
    test_multu_divu;
    test_div;
    test_mt_ignore;
    test_random;
    test_reset_mid;
`ifdef MDU_CANCEL_EN
    test_cancel;
`endif
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multiply/divide unit controller for the 5-stage MIPS pipeline. It owns the HI/LO registers and sequences mult, multu, div, divu, mthi and mtlo issued from the E stage. It emulates multi-cycle latency with a busy counter. Busy feeds the D-stage stall unit: any D-stage MDU instruction stalls while Start or Busy is high.

Parameters:
MULT_CYC, 5, busy cycles for mult/multu (legal 1..15)
DIV_CYC, 10, busy cycles for div/divu (legal 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; 0 clears all state
Start  input  1  one-cycle issue strobe from E stage
MDUOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
A  input  32  rs operand (E-stage forwarded)
B  input  32  rt operand (E-stage forwarded)
ReadSel  input  1  0 selects LO, 1 selects HI onto Out (mflo/mfhi)
Busy  output  1  operation in flight
HI  output  32  architectural HI
LO  output  32  architectural LO
Out  output  32  combinational: ReadSel ? HI : LO

Behaviour:
- Reset (reset=0, async): state IDLE, counter 0, Busy 0, HI 0, LO 0, pending registers 0. Out follows HI/LO immediately.
- States: IDLE and RUN.
- IDLE, Start=1, op 1-4:
  - compute result from A/B at the issuing edge;
  - latch 64-bit result into pending registers;
  - load counter with MULT_CYC or DIV_CYC;
  - go to RUN.
- IDLE, Start=1, op 5/6: write A into HI (mthi) or LO (mtlo) at that edge. No Busy, stay IDLE.
- IDLE, Start=1, op 0 or 7: no effect.
- RUN: Busy=1; counter decrements each edge. On the edge where counter goes 1->0, pending commits to HI/LO and state returns to IDLE.
- Latency: Start sampled at edge e0, N = configured cycle count.
  - Busy is 1 for exactly N cycles following e0.
  - New HI/LO is visible in the first cycle Busy=0.
- Start in RUN: ignored entirely, including mthi/mtlo; the stall unit guarantees this never occurs. Counter and pending are unaffected.
- Arithmetic:
  - mult: signed 32x32 -> 64 product; HI = [63:32], LO = [31:0].
  - multu: same as mult, unsigned.
  - div: signed; LO = quotient truncated toward zero; HI = remainder with sign of dividend.
  - divu: unsigned; LO = quotient, HI = remainder.
- Divide by zero (B=0, div/divu): full DIV_CYC busy period still runs; HI/LO remain unchanged at commit.
- Signed overflow case div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Reset mid-RUN: pending discarded, HI/LO cleared, Busy 0 asynchronously.
- Simultaneous commit and new Start on the same edge cannot happen, because Start in RUN is ignored. Start is only accepted from the cycle after Busy falls.

Optional Feature:
MDU_CANCEL_EN
- Defined: adds input Cancel (1 bit) for exception/flush of the issuing instruction.
  - Cancel=1 in RUN: at the next edge go to IDLE, Busy 0, pending dropped, HI/LO unchanged.
  - Cancel=1 with Start=1 in IDLE: the Start is discarded (no mthi/mtlo write, no RUN entry).
  - Cancel in IDLE without Start: no effect.
- Undefined: Cancel port absent; every accepted operation runs to commit.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release -> HI=0, LO=0, Busy=0, Out=0.
- mult: A=0xFFFFFFFE (-2), B=3 -> Busy 1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; HI/LO unchanged while Busy.
- multu then divu:
  - multu A=0xFFFFFFFF, B=2 -> HI=1, LO=0xFFFFFFFE after 5 busy cycles.
  - divu A=7, B=2 -> Busy 10 cycles, then LO=3, HI=1.
- div signed and by zero:
  - div A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Then div A=5, B=0 -> Busy 10 cycles, HI/LO still 0xFFFFFFFF/0xFFFFFFFD.
- mthi/mtlo and ignored Start:
  - mtlo A=0x1234 -> LO=0x1234 next cycle, Busy stays 0; ReadSel=0 gives Out=0x1234.
  - mult A=2, B=3 then mthi A=0x55 during Busy -> mthi ignored; after commit HI=0, LO=6.
- Reset mid-op / cancel:
  - mult issued, reset=0 at busy cycle 2 -> Busy, HI, LO go 0 immediately.
  - With MDU_CANCEL_EN: div issued, Cancel at busy cycle 3 -> Busy 0 next cycle, HI/LO keep prior values.
